ap_ctrl_txn_probe: RTL and testbench

- Synthesizable per-module transaction probe for HLS ap_ctrl handshakes.
- Watches one module's ap_start/ap_ready/ap_done/ap_continue and timestamps each transaction with a free-running cycle counter.
- Emits one record per completed transaction (start, done, latency, sequence) on a valid/ready stream.
- Sits directly upstream of the status dumper: the dumper consumes the record stream instead of sampling raw handshake levels.

---
 rtl/ap_ctrl_txn_probe_pkg.sv | 13 +
 rtl/ap_ctrl_txn_probe_fifo.sv | 40 ++++
 rtl/ap_ctrl_txn_probe.sv | 112 +++++++++++
 tb/tb_ap_ctrl_txn_probe.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/ap_ctrl_txn_probe_pkg.sv
// ap_probe_pkg: shared state, record type and constants for the ap_ctrl transaction probe
package ap_probe_pkg;
  localparam int SEQ_W = 16;
  localparam logic [15:0] CNT_SAT = 16'hFFFF;
  localparam int TS_W_DEF = 32;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} probe_state_e;
  typedef struct packed {
    logic [TS_W_DEF-1:0] start_ts;
    logic [TS_W_DEF-1:0] done_ts;
    logic [TS_W_DEF-1:0] latency;
    logic [SEQ_W-1:0]    seq;
  } probe_rec_t;
endpackage

// File: rtl/ap_ctrl_txn_probe_fifo.sv
// probe_rec_fifo: synchronous record FIFO with registered full/empty and same-cycle push/pop
module probe_rec_fifo import ap_probe_pkg::*; #(
  parameter int DEPTH = 8,
  parameter type T = probe_rec_t
) (
  input  logic clock,
  input  logic reset,
  input  logic push,
  input  T     din,
  input  logic pop,
  output T     dout,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  T mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic do_push, do_pop;
  always_comb begin
    do_pop = pop & ~empty;
    do_push = push & (~full | do_pop);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) mem_q[wr_q] <= din;
      wr_q <= wr_q + AW'(do_push);
      rd_q <= rd_q + AW'(do_pop);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  assign full = cnt_q[AW];
  assign empty = cnt_q == '0;
  assign dout = mem_q[rd_q];
endmodule

// File: rtl/ap_ctrl_txn_probe.sv
// ap_ctrl_txn_probe: timestamps ap_ctrl start/done handshakes and streams one record per transaction
module ap_ctrl_txn_probe import ap_probe_pkg::*; #(
  parameter int TS_W = 32,
  parameter int DEPTH = 8,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            ap_start,
  input  logic                            ap_ready,
  input  logic                            ap_done,
  input  logic                            ap_continue,
  input  logic                            finish,
  output logic                            rec_valid,
  input  logic                            rec_ready,
  output logic [TS_W-1:0]                 rec_start_ts,
  output logic [TS_W-1:0]                 rec_done_ts,
  output logic [TS_W-1:0]                 rec_latency,
  output logic [SEQ_W-1:0]                rec_seq,
  output logic [15:0]                     drop_count,
  output logic [$clog2(MAX_INFLIGHT):0]   inflight,
  output logic                            err_no_start,
  output logic                            err_start_ovf,
  output logic                            finished
);
  localparam int QW = MAX_INFLIGHT > 1 ? $clog2(MAX_INFLIGHT) : 1;
  localparam int IW = $clog2(MAX_INFLIGHT) + 1;
  typedef struct packed {
    logic [TS_W-1:0]  start_ts;
    logic [TS_W-1:0]  done_ts;
    logic [TS_W-1:0]  latency;
    logic [SEQ_W-1:0] seq;
  } rec_t;
  probe_state_e state_q;
  logic [TS_W-1:0] cnt_q;
  logic [TS_W-1:0] sq_q [MAX_INFLIGHT];
  logic [QW-1:0] rd_q, wr_q, rd_d, wr_d;
  logic [IW-1:0] inflight_q;
  logic [SEQ_W-1:0] seq_q;
  logic [15:0] drop_q;
  logic err_ns_q, err_ov_q;
  logic active, s_ev, d_ev, q_empty, q_full, q_pop, q_push, rec_push, drop;
  logic fifo_pop, fifo_full, fifo_empty;
  rec_t rec_d, head;
  always_comb begin
    active = state_q == IDLE || state_q == RUN;
    s_ev = active & ap_start & ap_ready;
    d_ev = active & ap_done & ap_continue;
    q_empty = inflight_q == '0;
    q_full = inflight_q == IW'(MAX_INFLIGHT);
    q_pop = d_ev & ~q_empty;
    // an empty-queue done with a same-cycle start consumes that start directly
    q_push = s_ev & ~(d_ev & q_empty) & (~q_full | q_pop);
    rec_push = d_ev & (~q_empty | s_ev);
    fifo_pop = ~fifo_empty & rec_ready;
    drop = rec_push & fifo_full & ~fifo_pop;
    rd_d = rd_q == QW'(MAX_INFLIGHT - 1) ? '0 : rd_q + 1'b1;
    wr_d = wr_q == QW'(MAX_INFLIGHT - 1) ? '0 : wr_q + 1'b1;
    rec_d.start_ts = q_empty ? cnt_q : sq_q[rd_q];
    rec_d.done_ts = cnt_q;
    rec_d.latency = cnt_q - rec_d.start_ts;
    rec_d.seq = seq_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      for (int i = 0; i < MAX_INFLIGHT; i++) sq_q[i] <= '0;
      rd_q <= '0;
      wr_q <= '0;
      inflight_q <= '0;
      seq_q <= '0;
      drop_q <= '0;
      err_ns_q <= 1'b0;
      err_ov_q <= 1'b0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
      if (q_push) sq_q[wr_q] <= cnt_q;
      if (d_ev) seq_q <= seq_q + 1'b1;
      if (d_ev & q_empty & ~s_ev) err_ns_q <= 1'b1;
      if (s_ev & q_full & ~d_ev) err_ov_q <= 1'b1;
      if (drop && drop_q != CNT_SAT) drop_q <= drop_q + 1'b1;
      // outstanding starts are abandoned when draining begins
      rd_q <= active & finish ? '0 : q_pop ? rd_d : rd_q;
      wr_q <= active & finish ? '0 : q_push ? wr_d : wr_q;
      inflight_q <= active & finish ? '0 : inflight_q + IW'(q_push) - IW'(q_pop);
      state_q <= active & finish ? DRAIN :
                 state_q == IDLE & s_ev ? RUN :
                 state_q == DRAIN & fifo_empty ? DONE : state_q;
    end
  end
  probe_rec_fifo #(.DEPTH(DEPTH), .T(rec_t)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (rec_push),
    .din   (rec_d),
    .pop   (fifo_pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );
  assign rec_valid = ~fifo_empty;
  assign rec_start_ts = head.start_ts;
  assign rec_done_ts = head.done_ts;
  assign rec_latency = head.latency;
  assign rec_seq = head.seq;
  assign drop_count = drop_q;
  assign inflight = inflight_q;
  assign err_no_start = err_ns_q;
  assign err_start_ovf = err_ov_q;
  assign finished = state_q == DONE;
endmodule

// File: tb/tb_ap_ctrl_txn_probe.sv
// tb_ap_ctrl_txn_probe: table vectors, directed corner sequences and a randomized queue-based reference model
module tb_ap_ctrl_txn_probe;
  localparam int TS_W = 8;
  localparam int DEPTH = 8;
  localparam int MAXI = 4;
  localparam int MASK = (1 << TS_W) - 1;
  logic clock = 0;
  logic reset, ap_start, ap_ready, ap_done, ap_continue, finish, rec_ready;
  logic rec_valid, err_no_start, err_start_ovf, finished;
  logic [TS_W-1:0] rec_start_ts, rec_done_ts, rec_latency;
  logic [15:0] rec_seq, drop_count;
  logic [$clog2(MAXI):0] inflight;
  always #5 clock = ~clock;
  ap_ctrl_txn_probe #(.TS_W(TS_W), .DEPTH(DEPTH), .MAX_INFLIGHT(MAXI)) dut (
    .clock(clock), .reset(reset), .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done),
    .ap_continue(ap_continue), .finish(finish), .rec_valid(rec_valid), .rec_ready(rec_ready),
    .rec_start_ts(rec_start_ts), .rec_done_ts(rec_done_ts), .rec_latency(rec_latency),
    .rec_seq(rec_seq), .drop_count(drop_count), .inflight(inflight),
    .err_no_start(err_no_start), .err_start_ovf(err_start_ovf), .finished(finished)
  );
  typedef struct {int st; int dn; int lat; int seq;} mrec_t;
  typedef struct {int s_at; int d_at; int e_st; int e_dn; int e_lat;} vec_t;
  mrec_t m_fifo[$];
  int m_q[$];
  int m_cnt, m_seq, m_drop, m_ph;
  bit m_ens, m_eov;
  int n_chk = 0, n_fail = 0;
  vec_t vecs[4];
  // reference: what one clock edge does to the observable probe state
  task automatic model_edge();
    bit s, d, act, had, took;
    int st, fsz;
    if (reset) begin
      m_cnt = 0; m_q.delete(); m_fifo.delete(); m_seq = 0; m_drop = 0;
      m_ens = 0; m_eov = 0; m_ph = 0;
      return;
    end
    act = m_ph < 2;
    s = act && ap_start && ap_ready;
    d = act && ap_done && ap_continue;
    fsz = m_fifo.size();
    if (fsz > 0 && rec_ready) void'(m_fifo.pop_front());
    had = 0; took = 0; st = 0;
    if (d) begin
      if (m_q.size() > 0) begin st = m_q.pop_front(); had = 1; end
      else if (s) begin st = m_cnt; had = 1; took = 1; end
      else m_ens = 1;
      if (had) begin
        if (m_fifo.size() < DEPTH) m_fifo.push_back('{st, m_cnt, (m_cnt - st) & MASK, m_seq});
        else if (m_drop < 65535) m_drop++;
      end
      m_seq = (m_seq + 1) & 16'hFFFF;
    end
    if (s && !took) begin
      if (m_q.size() < MAXI) m_q.push_back(m_cnt);
      else m_eov = 1;
    end
    if (act && finish) begin m_ph = 2; m_q.delete(); end
    else if (m_ph == 2 && fsz == 0) m_ph = 3;
    m_cnt = (m_cnt + 1) & MASK;
  endtask
  task automatic tick();
    model_edge();
    @(posedge clock);
    @(negedge clock);
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic chk_all();
    chk("m_valid", rec_valid, m_fifo.size() > 0);
    if (m_fifo.size() > 0) begin
      chk("m_start", rec_start_ts, m_fifo[0].st);
      chk("m_done", rec_done_ts, m_fifo[0].dn);
      chk("m_lat", rec_latency, m_fifo[0].lat);
      chk("m_seq", rec_seq, m_fifo[0].seq);
    end
    chk("m_inflight", inflight, m_q.size());
    chk("m_err_ns", err_no_start, m_ens);
    chk("m_err_ov", err_start_ovf, m_eov);
    chk("m_drop", drop_count, m_drop);
    chk("m_finished", finished, m_ph == 3);
  endtask
  task automatic do_reset();
    reset = 1; ap_start = 0; ap_ready = 1; ap_done = 0; ap_continue = 1; finish = 0; rec_ready = 1;
    tick();
    chk("rst_valid", rec_valid, 0);
    chk("rst_inflight", inflight, 0);
    chk("rst_errs", {err_no_start, err_start_ovf}, 0);
    chk("rst_drop", drop_count, 0);
    chk("rst_finished", finished, 0);
    chk("rst_fields", {rec_start_ts, rec_done_ts, rec_latency}, 0);
    reset = 0;
  endtask
  initial begin
    vecs[0] = '{5, 12, 5, 12, 7};
    vecs[1] = '{20, 20, 20, 20, 0};
    vecs[2] = '{250, 260, 250, 4, 10};
    vecs[3] = '{0, 1, 0, 1, 1};
    for (int v = 0; v < 4; v++) begin
      do_reset();
      for (int c = 0; c <= vecs[v].d_at; c++) begin
        ap_start = c == vecs[v].s_at;
        ap_done = c == vecs[v].d_at;
        if (c == vecs[v].d_at) chk("vec_pre_valid", rec_valid, 0);
        tick();
      end
      ap_start = 0; ap_done = 0;
      chk("vec_valid", rec_valid, 1);
      chk("vec_start", rec_start_ts, vecs[v].e_st);
      chk("vec_done", rec_done_ts, vecs[v].e_dn);
      chk("vec_lat", rec_latency, vecs[v].e_lat);
      chk("vec_seq", rec_seq, 0);
      chk("vec_inflight", inflight, 0);
      chk("vec_errs", {err_no_start, err_start_ovf}, 0);
      tick();
      chk("vec_popped", rec_valid, 0);
    end
    do_reset();
    for (int c = 0; c <= 13; c++) begin
      ap_start = c inside {2, 3, 4};
      ap_done = c inside {10, 11, 12};
      if (c == 5) chk("ovl_inflight", inflight, 3);
      if (c >= 11) begin
        chk("ovl_seq", rec_seq, c - 11);
        chk("ovl_start", rec_start_ts, c - 9);
        chk("ovl_lat", rec_latency, 8);
      end
      tick();
    end
    ap_start = 0; ap_done = 0;
    do_reset();
    rec_ready = 0; ap_start = 1; ap_done = 1;
    repeat (10) tick();
    ap_start = 0; ap_done = 0;
    chk("bp_drop", drop_count, 2);
    chk("bp_inflight", inflight, 0);
    rec_ready = 1;
    for (int i = 0; i < 8; i++) begin
      chk("bp_valid", rec_valid, 1);
      chk("bp_seq", rec_seq, i);
      tick();
    end
    chk("bp_empty", rec_valid, 0);
    ap_start = 1; ap_done = 1; tick(); ap_start = 0; ap_done = 0;
    chk("bp_next_seq", rec_seq, 10);
    do_reset();
    ap_done = 1; tick(); ap_done = 0;
    chk("ns_err", err_no_start, 1);
    chk("ns_norec", rec_valid, 0);
    ap_start = 1; ap_done = 1; tick(); ap_start = 0; ap_done = 0;
    chk("ns_seq_adv", rec_seq, 1);
    do_reset();
    ap_start = 1; repeat (5) tick(); ap_start = 0;
    chk("ovf_inflight", inflight, 4);
    chk("ovf_err", err_start_ovf, 1);
    chk("ovf_ns", err_no_start, 0);
    do_reset();
    rec_ready = 0; ap_start = 1; ap_done = 1;
    tick(); tick();
    ap_done = 0; tick();
    ap_start = 0; finish = 1;
    chk("fin_inflight_pre", inflight, 1);
    tick(); finish = 0;
    chk("fin_inflight_drop", inflight, 0);
    chk("fin_head0", rec_seq, 0);
    rec_ready = 1; ap_start = 1; ap_done = 1;
    tick();
    chk("fin_head1", rec_seq, 1);
    tick();
    chk("fin_empty", rec_valid, 0);
    chk("fin_not_yet", finished, 0);
    tick();
    chk("fin_done", finished, 1);
    chk("fin_ignored", {err_no_start, err_start_ovf, rec_valid}, 0);
    ap_start = 0; ap_done = 0; tick();
    chk("fin_held", finished, 1);
    do_reset();
    tick();
    chk("fin_cleared", finished, 0);
    do_reset();
    for (int b = 0; b < 4; b++) begin
      for (int c = 0; c < 500; c++) begin
        ap_start = $urandom_range(0, 2) == 0;
        ap_ready = $urandom_range(0, 1);
        ap_done = $urandom_range(0, 3) == 0;
        ap_continue = $urandom_range(0, 3) != 0;
        rec_ready = $urandom_range(0, 3) < b + 1;
        tick();
        chk_all();
      end
    end
    finish = 1; rec_ready = 1; tick(); finish = 0;
    for (int c = 0; c < 40 && !finished; c++) begin
      ap_start = $urandom_range(0, 1);
      ap_done = $urandom_range(0, 1);
      tick();
      chk_all();
    end
    chk("rand_drain_finished", finished, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
